// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the ALU, the result stage and its consumer.
interface alu_result_stage_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic [1:0]       op;
    logic             a_msb;
    logic             b_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    logic [CNT_W-1:0] res_count;
    logic             sticky_v;
    logic             clr_sticky;

    // ALU producer plus result consumer side
    modport master (
        output in_valid, s, cout, op, a_msb, b_msb, out_ready, clr_sticky,
        input  in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v,
               res_count, sticky_v
    );

    // Result stage side
    modport slave (
        input  in_valid, s, cout, op, a_msb, b_msb, out_ready, clr_sticky,
        output in_ready, out_valid, result, flag_c, flag_z, flag_n, flag_v,
               res_count, sticky_v
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result/flag stage: derives C/Z/N/V at push, buffers in a DEPTH-entry FIFO, 1-cycle latency.
// in_ready drops when full regardless of out_ready (no pass-through); res_count and sticky_v track pushes.
module alu_result_stage #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    alu_result_stage_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             z;
        logic             n;
        logic             v;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic [CNT_W-1:0] r_res_count;
    logic             r_sticky_v;

    logic   w_in_ready;
    logic   w_out_valid;
    logic   w_push;
    logic   w_pop;
    logic   w_is_arith;
    logic   w_beff;
    entry_t w_entry;
    entry_t w_head;

    // beff is the b sign as the adder sees it (inverted for SUB)
    always_comb begin
        w_is_arith  = bus.op[1];
        w_beff      = bus.b_msb ^ bus.op[0];
        w_entry.res = bus.s;
        w_entry.z   = (bus.s == '0);
        w_entry.n   = bus.s[WIDTH-1];
        w_entry.c   = w_is_arith & bus.cout;
        w_entry.v   = w_is_arith & (bus.a_msb ~^ w_beff) & (bus.s[WIDTH-1] ^ bus.a_msb);
    end

    always_comb begin
        w_in_ready  = (r_occ != OCC_W'(DEPTH)) & ~rst;
        w_out_valid = (r_occ != '0);
        w_push      = bus.in_valid & w_in_ready;
        w_pop       = w_out_valid & bus.out_ready;
        w_head      = r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_res_count <= '0;
            r_sticky_v  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
                r_res_count     <= r_res_count + CNT_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            // a new overflow takes priority over a same-cycle clear
            if (w_push && w_entry.v) begin
                r_sticky_v <= 1'b1;
            end else if (bus.clr_sticky) begin
                r_sticky_v <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = w_head.res;
    assign bus.flag_c    = w_head.c;
    assign bus.flag_z    = w_head.z;
    assign bus.flag_n    = w_head.n;
    assign bus.flag_v    = w_head.v;
    assign bus.res_count = r_res_count;
    assign bus.sticky_v  = r_sticky_v;
endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;
    localparam int WIDTH = 64;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    alu_result_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] r;
        logic [3:0]  f;   // {C,Z,N,V}
    } exp_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] op, input logic [63:0] s,
                          input logic c, input logic am, input logic bm);
        bus.in_valid = v;
        bus.op       = op;
        bus.s        = s;
        bus.cout     = c;
        bus.a_msb    = am;
        bus.b_msb    = bm;
    endtask

    function automatic logic [3:0] head_flags();
        return {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v};
    endfunction

    exp_t        q[$];
    int          m_count;
    logic        m_sticky;
    logic [63:0] a, b, sum;
    logic [64:0] uext;
    logic signed [64:0] sext;
    logic [1:0]  rop;
    logic        rc, rv, m_push, m_pop;
    exp_t        e;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        set_in(1'b0, 2'b00, '0, 1'b0, 1'b0, 1'b0);
        bus.out_ready  = 1'b0;
        bus.clr_sticky = 1'b0;

        // reset, held for two edges
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_count", bus.res_count, 0);
        check("rst_sticky", bus.sticky_v, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);
        check("idle_out_valid", bus.out_valid, 0);

        // ADD overflow
        set_in(1'b1, 2'b10, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("add_valid", bus.out_valid, 1);
        check("add_result", bus.result, 64'h8000_0000_0000_0000);
        check("add_flags", head_flags(), 4'b0011);
        check("add_sticky", bus.sticky_v, 1);
        check("add_count", bus.res_count, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // SUB giving zero with carry
        set_in(1'b1, 2'b11, 64'h0, 1'b1, 1'b1, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("sub_flags", head_flags(), 4'b1100);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // XOR: carry ignored
        set_in(1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("xor_flags", head_flags(), 4'b0010);
        check("xor_count", bus.res_count, 3);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // backpressure and ordering, from a clean reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(1'b1, 2'b01, 64'd1, 1'b0, 1'b0, 1'b0);
        tick();
        bus.s = 64'd2;
        tick();
        bus.s = 64'd3;
        @(negedge clk);
        check("bp_full_in_ready", bus.in_ready, 0);
        check("bp_full_valid", bus.out_valid, 1);
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_out1", bus.result, 1);
        check("bp_out1_in_ready", bus.in_ready, 0);
        tick();
        @(negedge clk);
        check("bp_out2", bus.result, 2);
        check("bp_out2_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_out3", bus.result, 3);
        check("bp_out3_valid", bus.out_valid, 1);
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_drained", bus.out_valid, 0);
        check("bp_count", bus.res_count, 3);

        // sticky set/clear race, then flush by reset
        bus.clr_sticky = 1'b1;
        set_in(1'b1, 2'b10, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("race_sticky", bus.sticky_v, 1);
        tick();
        bus.clr_sticky = 1'b0;
        @(negedge clk);
        check("clr_sticky", bus.sticky_v, 0);
        set_in(1'b1, 2'b01, 64'd5, 1'b0, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("held_valid", bus.out_valid, 1);
        check("held_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("flush_valid", bus.out_valid, 0);
        check("flush_count", bus.res_count, 0);
        check("flush_result", bus.result, 0);
        check("flush_in_ready", bus.in_ready, 0);
        tick();
        rst = 1'b0;

        // randomized traffic against a queue model
        m_count  = 0;
        m_sticky = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            a   = {$urandom, $urandom};
            b   = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
            rop = 2'($urandom_range(0, 3));
            case (rop)
                2'b00: begin sum = ~(a | b); rc = 1'b0; rv = 1'b0; end
                2'b01: begin sum = a ^ b;    rc = 1'b0; rv = 1'b0; end
                2'b10: begin
                    uext = {1'b0, a} + {1'b0, b};
                    sext = $signed({a[63], a}) + $signed({b[63], b});
                    sum = uext[63:0]; rc = uext[64]; rv = sext[64] ^ sext[63];
                end
                default: begin
                    uext = {1'b0, a} + {1'b0, ~b} + 65'd1;
                    sext = $signed({a[63], a}) - $signed({b[63], b});
                    sum = uext[63:0]; rc = uext[64]; rv = sext[64] ^ sext[63];
                end
            endcase
            set_in(1'($urandom_range(0, 1)), rop, sum,
                   rop[1] ? rc : 1'($urandom_range(0, 1)), a[63], b[63]);
            bus.out_ready  = 1'($urandom_range(0, 1));
            bus.clr_sticky = ($urandom_range(0, 9) == 0);
            e.r = sum;
            e.f = {rc, (sum == 64'd0), sum[63], rv};

            @(negedge clk);
            check("rnd_in_ready", bus.in_ready, (q.size() != DEPTH));
            check("rnd_out_valid", bus.out_valid, (q.size() != 0));
            check("rnd_count", bus.res_count, 64'(m_count));
            check("rnd_sticky", bus.sticky_v, m_sticky);
            if (q.size() != 0) begin
                check("rnd_result", bus.result, q[0].r);
                check("rnd_flags", head_flags(), q[0].f);
            end
            m_push = bus.in_valid && (q.size() != DEPTH);
            m_pop  = bus.out_ready && (q.size() != 0);
            tick();
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back(e);
                m_count = (m_count + 1) % (1 << CNT_W);
            end
            if (m_push && e.f[0]) m_sticky = 1'b1;
            else if (bus.clr_sticky) m_sticky = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream register/flag stage for the 64-bit ALU (alu64bit).
- Captures each ALU result (s, cout) together with the op and operand sign bits that produced it, then derives the C/Z/N/V condition flags.
- Buffers results in a small FIFO and presents them to the consumer through a valid/ready handshake.
- Also keeps an accepted-result counter and a sticky overflow bit for the control logic.

Parameters:
- WIDTH, 64, data width of ALU result
- DEPTH, 2, FIFO entries (power of 2, at least 2)
- CNT_W, 16, width of accepted-result counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  ALU result valid
- in_ready  output  1  stage can accept a result
- s  input  WIDTH  ALU sum/logic result
- cout  input  1  ALU carry out
- op  input  2  ALU op: 00 NOR, 01 XOR, 10 ADD, 11 SUB
- a_msb  input  1  bit WIDTH-1 of operand a
- b_msb  input  1  bit WIDTH-1 of operand b, before any inversion
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head entry
- result  output  WIDTH  head entry result
- flag_c, flag_z, flag_n, flag_v  output  1 each  head entry flags
- res_count  output  CNT_W  number of results accepted since reset
- sticky_v  output  1  set when any accepted entry has V=1
- clr_sticky  input  1  clears sticky_v

Behaviour:
- Reset (rst=1 at a clock edge): all FIFO storage, pointers, occupancy, res_count and sticky_v go to 0.
  - out_valid=0; result and flags read 0.
  - in_ready=0 while rst is high, and 1 in the first cycle after rst deasserts.
  - rst asserted mid-operation discards all buffered entries; no partial output.
- Push: occurs when in_valid & in_ready at a rising edge.
  - in_ready = (occupancy != DEPTH) & ~rst, purely combinational from registered state.
  - in_ready does not depend on out_ready: no pass-through when full.
- Pop: occurs when out_valid & out_ready at a rising edge.
  - out_valid = (occupancy != 0).
  - result and flags are registered FIFO-head outputs, with no combinational path from s/op.
- Latency: an entry pushed at edge N is visible on result/out_valid after edge N (cycle N+1) when the FIFO was empty. Throughput is 1 entry per cycle.
- Simultaneous push and pop: occupancy is unchanged, pointers both advance, and ordering is strict FIFO.
  - When full, push cannot occur. A pop in that cycle frees a slot, and in_ready rises the next cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- Flags are computed at push time and stored with the entry:
  - Z = (s == 0), for all ops.
  - N = s[WIDTH-1], for all ops.
  - C = cout for op 10/11; 0 for op 00/01.
  - V for op 10/11: beff = b_msb ^ op[0]; V = (a_msb ~^ beff) & (s[WIDTH-1] ^ a_msb). V is 0 for op 00/01.
- res_count increments by 1 on each push, wraps at 2^CNT_W to 0, and is unaffected by pops.
- sticky_v is set on a push whose V=1.
  - It is cleared by clr_sticky=1 at an edge.
  - If set and clear occur in the same edge, set wins (sticky_v=1).
- Inputs are ignored when no push occurs. The values of s/op/cout/a_msb/b_msb when in_valid=0 have no effect.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0.
  - Required: out_valid=0, res_count=0, sticky_v=0, and in_ready=0 during reset then 1.
- ADD overflow: push op=10, s=64'h8000_0000_0000_0000, cout=0, a_msb=0, b_msb=0.
  - Required next cycle: out_valid=1, result=8000..0, N=1, Z=0, C=0, V=1, sticky_v=1, res_count=1.
- SUB zero/carry: push op=11, s=0, cout=1, a_msb=1, b_msb=1.
  - Required: Z=1, C=1, N=0, V=0.
- Logic op: push op=01, s=64'hFFFF_FFFF_FFFF_FFFF, cout=1.
  - Required: C=0, V=0, N=1, Z=0.
- Backpressure and ordering: with out_ready=0, push 3 consecutive results 1,2,3.
  - Required: 1 and 2 are accepted and in_ready=0 on the 3rd.
  - Then raise out_ready with in_valid still high.
  - Required: outputs 1,2,3 in order, with no loss or duplication, and res_count=3.
- Set/clear race and reset flush: push a V=1 entry while clr_sticky=1.
  - Required: sticky_v=1.
  - Then clr_sticky alone. Required: sticky_v=0.
  - Then with 2 entries held, assert rst. Required: out_valid=0 next cycle and res_count=0.
